palette_lookup_arbiter: RTL and testbench

Shares one sprite palette lookup port between several sprite renderers that each need an index-to-RGB conversion per pixel. Grants requesters round-robin, drives the shared palette bank/index, captures the returned 12-bit colour, and returns it tagged with the requester ID through a valid/ready response port. Sits between the per-sprite renderers and the combinational palette bank mux, which is instantiated outside this block, ahead of the VGA colour mapper.

---
 rtl/palette_lookup_arbiter_pkg.sv | 35 +++
 rtl/palette_lookup_arbiter_if.sv | 28 ++
 rtl/palette_lookup_arbiter_rr_grant.sv | 42 ++++
 rtl/palette_lookup_arbiter.sv | 98 +++++++++
 tb/tb_palette_lookup_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/palette_lookup_arbiter_pkg.sv
// Shared palette types plus the round-robin search used by the palette lookup arbiter.
package palette_arb_pkg;

   localparam int PAL_IDX_W  = 4;
   localparam int RGB_W      = 12;
   localparam int MAX_REQ    = 8;
   localparam int MAX_BANK_W = 8;

   typedef logic [11:0] rgb_t;

   typedef struct packed {
      logic [MAX_BANK_W-1:0] bank;
      logic [PAL_IDX_W-1:0]  index;
   } pal_req_t;

   // First asserted requester after ptr, wrapping modulo num; all zeros when none.
   function automatic logic [MAX_REQ-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                  input int unsigned ptr,
                                                  input int unsigned num);
      logic [MAX_REQ-1:0] grant;
      int unsigned        idx;
      logic               found;
      grant = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         idx = (ptr + k) % num;
         if (k <= num && !found && valid[idx[2:0]]) begin
            grant[idx[2:0]] = 1'b1;
            found           = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Request, shared-palette and response signals of the palette lookup arbiter.
interface palette_lookup_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int BANK_W  = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*4-1:0]      req_index;
   logic [NUM_REQ*BANK_W-1:0] req_bank;
   logic [BANK_W-1:0]         pal_bank;
   logic [3:0]                pal_index;
   logic [11:0]               pal_rgb;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [ID_W-1:0]           rsp_id;
   logic [11:0]               rsp_rgb;

   modport slave (
      input  req_valid, req_index, req_bank, pal_rgb, rsp_ready,
      output req_ready, pal_bank, pal_index, rsp_valid, rsp_id, rsp_rgb
   );

   modport master (
      output req_valid, req_index, req_bank, pal_rgb, rsp_ready,
      input  req_ready, pal_bank, pal_index, rsp_valid, rsp_id, rsp_rgb
   );
endinterface

// File: rtl/palette_lookup_arbiter_rr_grant.sv
// Round-robin grant over the requesters; ptr remembers the last requester served.
module palette_rr_grant
   import palette_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               accept,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]    grant_id
);

   logic [ID_W-1:0]    ptr;
   logic [MAX_REQ-1:0] valid_ext;
   logic [MAX_REQ-1:0] grant_ext;
   logic               unused_grant_hi;

   assign valid_ext       = MAX_REQ'(req_valid);
   assign grant_ext       = rr_next(valid_ext, 32'(ptr), NUM_REQ);
   assign grant_onehot    = grant_ext[NUM_REQ-1:0];
   assign unused_grant_hi = |grant_ext;

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_onehot[i]) grant_id = ID_W'(i);
      end
   end

   // Reset points at the last requester so requester 0 wins the first search.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ptr <= ID_W'(NUM_REQ - 1);
      end else if (accept && (|req_valid)) begin
         ptr <= grant_id;
      end
   end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Two-stage palette lookup shared by several sprite renderers: S1 drives the palette, S2 holds the tagged colour.
module palette_lookup_arbiter
   import palette_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int BANK_W  = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input logic                   Clk,
   input logic                   Reset,
   palette_lookup_arbiter_if.slave bus
);

   logic                 s1_valid;
   logic [ID_W-1:0]      s1_id;
   pal_req_t             s1_req;
   logic                 rsp_valid_q;
   logic [ID_W-1:0]      rsp_id_q;
   rgb_t                 rsp_rgb_q;

   logic                 s2_free;
   logic                 s1_adv;
   logic                 accept;
   logic                 take;
   logic [NUM_REQ-1:0]   grant_onehot;
   logic [ID_W-1:0]      grant_id;
   logic [BANK_W-1:0]    sel_bank;
   logic [PAL_IDX_W-1:0] sel_index;
   logic                 unused_bank_hi;

   assign s2_free = !rsp_valid_q || bus.rsp_ready;
   assign s1_adv  = s1_valid && s2_free;
   assign accept  = !s1_valid || s1_adv;
   assign take    = accept && (|bus.req_valid);

   palette_rr_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_grant (
      .Clk          (Clk),
      .Reset        (Reset),
      .req_valid    (bus.req_valid),
      .accept       (accept),
      .grant_onehot (grant_onehot),
      .grant_id     (grant_id)
   );

   // Reset gates ready so nothing appears accepted while the pipeline is being cleared.
   assign bus.req_ready = {NUM_REQ{accept && !Reset}} & grant_onehot;

   always_comb begin
      sel_bank  = '0;
      sel_index = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_onehot[i]) begin
            sel_bank  = bus.req_bank[i*BANK_W +: BANK_W];
            sel_index = bus.req_index[i*PAL_IDX_W +: PAL_IDX_W];
         end
      end
   end

   // S1 keeps its bank/index after emptying so the palette inputs never glitch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_req   <= '0;
      end else if (take) begin
         s1_valid <= 1'b1;
         s1_id    <= grant_id;
         s1_req   <= '{bank: MAX_BANK_W'(sel_bank), index: sel_index};
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rgb_q   <= '0;
      end else if (s1_adv) begin
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= s1_id;
         rsp_rgb_q   <= bus.pal_rgb;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.pal_bank    = s1_req.bank[BANK_W-1:0];
   assign bus.pal_index   = s1_req.index;
   assign unused_bank_hi  = |s1_req.bank;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_rgb     = rsp_rgb_q;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Self-checking bench for palette_lookup_arbiter: directed scenarios plus randomized traffic against an in-order queue model.
module tb_palette_lookup_arbiter;
   import palette_arb_pkg::*;

   logic Clk;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;

   palette_lookup_arbiter_if #(.NUM_REQ(4), .BANK_W(2)) bus ();

   palette_lookup_arbiter #(.NUM_REQ(4), .BANK_W(2)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Bank 0 carries the snake palette entries; other banks are fixed distinct tables.
   function automatic rgb_t pal_table(input logic [1:0] bank, input logic [3:0] idx);
      case (bank)
         2'd0: begin
            case (idx)
               4'd1:    return 12'hE00;
               4'd3:    return 12'hB85;
               4'd7:    return 12'h084;
               default: return {idx, idx ^ 4'hA, 4'h1};
            endcase
         end
         2'd1:    return {~idx, idx, 4'hC};
         2'd2:    return {idx, 4'h3, ~idx};
         default: return {4'h7, idx, idx};
      endcase
   endfunction

   assign bus.pal_rgb = pal_table(bus.pal_bank, bus.pal_index);

   typedef struct {
      int         id;
      rgb_t       rgb;
      bit         out;
      logic [1:0] bank;
      logic [3:0] idx;
   } txn_t;

   txn_t mq[$];
   int   m_ptr   = 3;
   bit   m_hs    = 1'b0;
   int   m_hs_id = 0;

   function automatic int exp_grant(input logic [3:0] v, input int ptr);
      for (int k = 1; k <= 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   // In-flight transactions in order; at most two, and the head becomes visible once it has moved out of lookup.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mq.delete();
         m_ptr = 3;
         m_hs  = 1'b0;
      end else begin : model_step
         bit   acc;
         int   g;
         txn_t t;
         acc  = (mq.size() < 2) || bus.rsp_ready;
         g    = exp_grant(bus.req_valid, m_ptr);
         m_hs = 1'b0;
         if (mq.size() > 0 && mq[0].out && bus.rsp_ready) void'(mq.pop_front());
         if (mq.size() > 0 && !mq[0].out) mq[0].out = 1'b1;
         if (acc && g >= 0) begin
            t.id   = g;
            t.bank = bus.req_bank[g*2 +: 2];
            t.idx  = bus.req_index[g*4 +: 4];
            t.rgb  = pal_table(t.bank, t.idx);
            t.out  = 1'b0;
            mq.push_back(t);
            m_ptr   = g;
            m_hs    = 1'b1;
            m_hs_id = g;
         end
      end
   end

   // Continuous comparison of DUT outputs against the queue model, mid-cycle.
   always @(negedge Clk) begin : monitor
      logic [3:0] er;
      int         g;
      bit         ev;
      er = 4'b0000;
      g  = exp_grant(bus.req_valid, m_ptr);
      if (!Reset && ((mq.size() < 2) || bus.rsp_ready) && g >= 0) er[g] = 1'b1;
      checks++;
      if (bus.req_ready !== er) begin
         failures++;
         $display("[TB] FAIL model_req_ready: got %b expected %b at %0t", bus.req_ready, er, $time);
      end
      ev = (mq.size() > 0) && mq[0].out;
      checks++;
      if (bus.rsp_valid !== ev) begin
         failures++;
         $display("[TB] FAIL model_rsp_valid: got %b expected %b at %0t", bus.rsp_valid, ev, $time);
      end
      if (ev) begin
         checks++;
         if (bus.rsp_id !== 2'(mq[0].id) || bus.rsp_rgb !== mq[0].rgb) begin
            failures++;
            $display("[TB] FAIL model_rsp_data: got id=%0d rgb=%h expected id=%0d rgb=%h at %0t",
                     bus.rsp_id, bus.rsp_rgb, mq[0].id, mq[0].rgb, $time);
         end
      end
      if (mq.size() > 0 && !mq[mq.size()-1].out) begin
         checks++;
         if (bus.pal_index !== mq[mq.size()-1].idx || bus.pal_bank !== mq[mq.size()-1].bank) begin
            failures++;
            $display("[TB] FAIL model_pal_lookup: got bank=%0d idx=%0d expected bank=%0d idx=%0d at %0t",
                     bus.pal_bank, bus.pal_index, mq[mq.size()-1].bank, mq[mq.size()-1].idx, $time);
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input logic [3:0] idx, input logic [1:0] bank);
      bus.req_valid[i]        = v;
      bus.req_index[i*4 +: 4] = idx;
      bus.req_bank[i*2 +: 2]  = bank;
   endtask

   task automatic drain();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      repeat (4) cyc();
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      Reset         = 1'b1;
      bus.req_valid = 4'b1111;
      bus.req_index = 16'h1234;
      bus.req_bank  = 8'h1B;
      bus.rsp_ready = 1'b0;
      repeat (2) cyc();
      @(negedge Clk);
      checks++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_handshake: got ready=%b rsp_valid=%b expected 0000/0", bus.req_ready, bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_id !== 2'd0 || bus.rsp_rgb !== 12'h000 || bus.pal_bank !== 2'd0 || bus.pal_index !== 4'd0) begin
         failures++;
         $display("[TB] FAIL reset_values: got id=%0d rgb=%h bank=%0d idx=%0d expected all zero",
                  bus.rsp_id, bus.rsp_rgb, bus.pal_bank, bus.pal_index);
      end
      cyc();
      bus.req_valid = 4'b0000;
      bus.rsp_ready = 1'b1;
      Reset         = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic test_single();
      $display("[TB] test_single");
      set_req(0, 1'b1, 4'd1, 2'd0);
      bus.rsp_ready = 1'b1;
      @(negedge Clk);
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL single_ready: got %b expected 0001", bus.req_ready);
      end
      cyc();
      set_req(0, 1'b0, 4'd0, 2'd0);
      @(negedge Clk);
      checks++;
      if (bus.pal_index !== 4'd1 || bus.pal_bank !== 2'd0 || bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_lookup: got idx=%0d bank=%0d rsp_valid=%b expected 1/0/0",
                  bus.pal_index, bus.pal_bank, bus.rsp_valid);
      end
      cyc();
      @(negedge Clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_rgb !== 12'hE00) begin
         failures++;
         $display("[TB] FAIL single_rsp: got v=%b id=%0d rgb=%h expected 1/0/e00", bus.rsp_valid, bus.rsp_id, bus.rsp_rgb);
      end
      cyc();
      @(negedge Clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL single_rsp_clear: got %b expected 0", bus.rsp_valid);
      end
      drain();
   endtask

   task automatic test_all_four();
      $display("[TB] test_all_four");
      pulse_reset();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'($urandom), 2'($urandom));
      set_req(2, 1'b1, 4'd7, 2'd0);
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         checks++;
         if (bus.req_ready !== (4'b0001 << (i % 4))) begin
            failures++;
            $display("[TB] FAIL rr_order: cycle %0d got %b expected %b", i, bus.req_ready, 4'b0001 << (i % 4));
         end
         if (i >= 2) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'((i - 2) % 4)) begin
               failures++;
               $display("[TB] FAIL rr_rsp_stream: cycle %0d got v=%b id=%0d expected 1/%0d", i, bus.rsp_valid, bus.rsp_id, (i - 2) % 4);
            end
            if ((i - 2) % 4 == 2) begin
               checks++;
               if (bus.rsp_rgb !== 12'h084) begin
                  failures++;
                  $display("[TB] FAIL rr_req2_rgb: got %h expected 084", bus.rsp_rgb);
               end
            end
         end
         cyc();
      end
      drain();
   endtask

   task automatic test_backpressure();
      int         nsent = 0;
      int         nrecv = 0;
      rgb_t       sent[$];
      rgb_t       held_rgb;
      logic [1:0] held_id;
      logic [3:0] cur_idx;
      bit         hs;
      $display("[TB] test_backpressure");
      held_rgb = '0;
      held_id  = '0;
      cur_idx  = 4'd5;
      set_req(1, 1'b1, cur_idx, 2'd0);
      for (int c = 0; c < 25; c++) begin
         bus.rsp_ready = !(c >= 3 && c < 8);
         @(negedge Clk);
         hs = bus.req_valid[1] && bus.req_ready[1];
         if (hs) sent.push_back(pal_table(2'd0, cur_idx));
         if (c >= 3 && c < 8) begin
            checks++;
            if (bus.req_ready !== 4'b0000) begin
               failures++;
               $display("[TB] FAIL bp_ready_low: cycle %0d got %b expected 0000", c, bus.req_ready);
            end
            if (c == 3) begin
               held_rgb = bus.rsp_rgb;
               held_id  = bus.rsp_id;
            end else begin
               checks++;
               if (bus.rsp_valid !== 1'b1 || bus.rsp_rgb !== held_rgb || bus.rsp_id !== held_id) begin
                  failures++;
                  $display("[TB] FAIL bp_rsp_hold: cycle %0d got v=%b id=%0d rgb=%h expected 1/%0d/%h",
                           c, bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, held_id, held_rgb);
               end
            end
         end
         if (c == 8) begin
            checks++;
            if (bus.req_ready !== 4'b0010) begin
               failures++;
               $display("[TB] FAIL bp_release_accept: got %b expected 0010", bus.req_ready);
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            checks++;
            if (nrecv >= sent.size() || bus.rsp_id !== 2'd1 || bus.rsp_rgb !== sent[nrecv]) begin
               failures++;
               $display("[TB] FAIL bp_rsp_order: response %0d got id=%0d rgb=%h sent=%0d",
                        nrecv, bus.rsp_id, bus.rsp_rgb, sent.size());
            end
            nrecv++;
         end
         cyc();
         if (hs) begin
            nsent++;
            cur_idx = 4'(nsent + 5);
            set_req(1, nsent < 10, cur_idx, 2'd0);
         end
      end
      checks++;
      if (nsent != 10 || nrecv != 10) begin
         failures++;
         $display("[TB] FAIL bp_count: got sent=%0d received=%0d expected 10/10", nsent, nrecv);
      end
      drain();
   endtask

   task automatic test_fairness();
      bit got = 1'b0;
      $display("[TB] test_fairness");
      pulse_reset();
      set_req(0, 1'b1, 4'($urandom), 2'($urandom));
      bus.rsp_ready = 1'b1;
      repeat (2) cyc();
      set_req(3, 1'b1, 4'($urandom), 2'($urandom));
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge Clk);
         if (bus.req_ready[3]) got = 1'b1;
         else cyc();
      end
      checks++;
      if (!got || bus.req_ready !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL fair_req3_grant: got %b within 4 cycles expected 1000", bus.req_ready);
      end
      cyc();
      set_req(3, 1'b0, 4'd0, 2'd0);
      @(negedge Clk);
      checks++;
      if (bus.req_ready !== 4'b0001) begin
         failures++;
         $display("[TB] FAIL fair_wrap_to_0: got %b expected 0001", bus.req_ready);
      end
      drain();
   endtask

   task automatic test_reset_midop();
      bit got = 1'b0;
      $display("[TB] test_reset_midop");
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'($urandom), 2'($urandom));
      bus.rsp_ready = 1'b0;
      repeat (3) cyc();
      @(negedge Clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL midop_full: got v=%b ready=%b expected 1/0000", bus.rsp_valid, bus.req_ready);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL midop_reset_now: got v=%b ready=%b expected 0/0000", bus.rsp_valid, bus.req_ready);
      end
      repeat (2) cyc();
      set_req(0, 1'b1, 4'd3, 2'd0);
      bus.rsp_ready = 1'b1;
      Reset         = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(negedge Clk);
         if (bus.rsp_valid) got = 1'b1;
         else cyc();
         if (i == 0) set_req(0, 1'b0, 4'd0, 2'd0);
      end
      checks++;
      if (!got || bus.rsp_id !== 2'd0 || bus.rsp_rgb !== 12'hB85) begin
         failures++;
         $display("[TB] FAIL midop_first_rsp: got v=%b id=%0d rgb=%h expected 1/0/b85", got, bus.rsp_id, bus.rsp_rgb);
      end
      drain();
   endtask

   task automatic test_bank();
      $display("[TB] test_bank");
      set_req(1, 1'b1, 4'd1, 2'd1);
      bus.rsp_ready = 1'b1;
      @(negedge Clk);
      checks++;
      if (bus.req_ready !== 4'b0010) begin
         failures++;
         $display("[TB] FAIL bank_ready: got %b expected 0010", bus.req_ready);
      end
      cyc();
      set_req(1, 1'b0, 4'd0, 2'd0);
      @(negedge Clk);
      checks++;
      if (bus.pal_bank !== 2'd1 || bus.pal_index !== 4'd1) begin
         failures++;
         $display("[TB] FAIL bank_lookup: got bank=%0d idx=%0d expected 1/1", bus.pal_bank, bus.pal_index);
      end
      cyc();
      @(negedge Clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_rgb !== pal_table(2'd1, 4'd1)) begin
         failures++;
         $display("[TB] FAIL bank_rsp: got v=%b id=%0d rgb=%h expected 1/1/%h",
                  bus.rsp_valid, bus.rsp_id, bus.rsp_rgb, pal_table(2'd1, 4'd1));
      end
      drain();
   endtask

   task automatic test_random();
      $display("[TB] test_random");
      for (int c = 0; c < 300; c++) begin
         cyc();
         if (m_hs) bus.req_valid[m_hs_id] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, 4'($urandom), 2'($urandom));
         end
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
      end
      drain();
   endtask

   initial begin
      Reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_index = '0;
      bus.req_bank  = '0;
      bus.rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_fairness();
      test_reset_midop();
      test_bank();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
